fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 90 +++++++++
 tb/tb_fetch_queue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO between IF and decode carrying
// {pc, instr, pred_taken}, with flush on redirect and occupancy reporting.
package general_defines;
  localparam int unsigned XLEN = 32;
endpackage

module fetch_queue
  import general_defines::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [XLEN-1:0]            enq_pc,
  input  logic [XLEN-1:0]            enq_instr,
  input  logic                       enq_pred_taken,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_pc,
  output logic [XLEN-1:0]            deq_instr,
  output logic                       deq_pred_taken,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [DEPTH-1:0] pred_mem;

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic          enq_fire;
  logic          deq_fire;

  // Handshake status depends only on registered occupancy, so there is no
  // combinational path from deq_ready to enq_ready.
  always_comb begin
    enq_ready   = (count != CW'(DEPTH));
    deq_valid   = (count != '0);
    almost_full = (count >= CW'(DEPTH - 1));
    enq_fire    = enq_valid && enq_ready;
    deq_fire    = deq_valid && deq_ready;
  end

  always_comb begin
    deq_pc         = pc_mem[head_q];
    deq_instr      = instr_mem[head_q];
    deq_pred_taken = pred_mem[head_q];
  end

  // Storage carries no reset; validity is tracked purely by count.
  always_ff @(posedge clk) begin
    if (enq_fire && !flush) begin
      pc_mem[tail_q]    <= enq_pc;
      instr_mem[tail_q] <= enq_instr;
      pred_mem[tail_q]  <= enq_pred_taken;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      count  <= '0;
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) begin
        tail_q <= tail_q + PW'(1);
      end
      if (deq_fire) begin
        head_q <= head_q + PW'(1);
      end
      if (enq_fire && !deq_fire) begin
        count <= count + CW'(1);
      end else if (deq_fire && !enq_fire) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=8, XLEN=32): reset,
// single transfer, fill/overflow, full-with-dequeue, wrap stream, flush, async reset.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        pr;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [31:0] enq_instr;
  logic        enq_pred_taken;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic        deq_pred_taken;
  logic        flush;
  logic [3:0]  count;
  logic        almost_full;

  int     checks = 0;
  int     errors = 0;
  int     out_cnt;
  entry_t mq[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .enq_valid      (enq_valid),
    .enq_ready      (enq_ready),
    .enq_pc         (enq_pc),
    .enq_instr      (enq_instr),
    .enq_pred_taken (enq_pred_taken),
    .deq_valid      (deq_valid),
    .deq_ready      (deq_ready),
    .deq_pc         (deq_pc),
    .deq_instr      (deq_instr),
    .deq_pred_taken (deq_pred_taken),
    .flush          (flush),
    .count          (count),
    .almost_full    (almost_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, check the visible head against the model, then step
  // the model and check occupancy after the edge.
  task automatic cycle(input bit en, input logic [31:0] pc, input logic [31:0] ins,
                       input bit pr, input bit dr, input bit fl);
    int unsigned sz;
    entry_t      e;
    enq_valid      = en;
    enq_pc         = pc;
    enq_instr      = ins;
    enq_pred_taken = pr;
    deq_ready      = dr;
    flush          = fl;
    sz = mq.size();
    check("deq_valid", {63'd0, deq_valid}, {63'd0, sz != 0});
    check("enq_ready", {63'd0, enq_ready}, {63'd0, sz != DEPTH});
    if (sz != 0) begin
      check("head_pc", {32'd0, deq_pc}, {32'd0, mq[0].pc});
      check("head_instr", {32'd0, deq_instr}, {32'd0, mq[0].ins});
      check("head_pred", {63'd0, deq_pred_taken}, {63'd0, mq[0].pr});
    end
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      if (dr && sz != 0) begin
        void'(mq.pop_front());
        out_cnt++;
      end
      if (en && sz != DEPTH) begin
        e.pc = pc;
        e.ins = ins;
        e.pr = pr;
        mq.push_back(e);
      end
    end
    check("count", {60'd0, count}, 64'(mq.size()));
    check("almost_full", {63'd0, almost_full}, {63'd0, mq.size() >= DEPTH - 1});
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    int idx;
    rst = 1'b0;
    enq_valid = 1'b0;
    enq_pc = '0;
    enq_instr = '0;
    enq_pred_taken = 1'b0;
    deq_ready = 1'b0;
    flush = 1'b0;
    out_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", {60'd0, count}, 64'd0);
    check("rst_deq_valid", {63'd0, deq_valid}, 64'd0);
    check("rst_enq_ready", {63'd0, enq_ready}, 64'd1);
    check("rst_almost_full", {63'd0, almost_full}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // single entry, no bypass
    enq_valid = 1'b1;
    check("no_bypass", {63'd0, deq_valid}, 64'd0);
    cycle(1, 32'h100, 32'h00500093, 0, 0, 0);
    check("first_pc", {32'd0, deq_pc}, 64'h100);
    check("first_instr", {32'd0, deq_instr}, 64'h00500093);
    check("first_count", {60'd0, count}, 64'd1);
    cycle(0, 0, 0, 0, 1, 0);

    // fill to full, then overflow offer is dropped
    for (int i = 0; i < 8; i++)
      cycle(1, 32'h1000 + 32'(i * 4), 32'hA000 + 32'(i), i[0], 0, 0);
    check("full_count", {60'd0, count}, 64'd8);
    check("full_enq_ready", {63'd0, enq_ready}, 64'd0);
    cycle(1, 32'hDEAD, 32'hDEAD, 1, 0, 0);
    check("drop_count", {60'd0, count}, 64'd8);
    check("hold_pc", {32'd0, deq_pc}, 64'h1000);

    // full with both sides active: dequeue only, enqueue lands next cycle
    cycle(1, 32'h2000, 32'hB000, 1, 1, 0);
    check("full_deq_count", {60'd0, count}, 64'd7);
    check("full_deq_head", {32'd0, deq_pc}, 64'h1004);
    cycle(1, 32'h2000, 32'hB000, 1, 0, 0);
    check("refill_count", {60'd0, count}, 64'd8);
    for (int c = 0; c < 64 && mq.size() != 0; c++)
      cycle(0, 0, 0, 0, 1, 0);
    check("drained", {60'd0, count}, 64'd0);

    // sequential PC stream across wrap with random deq_ready
    out_cnt = 0;
    idx = 0;
    for (int c = 0; c < 300 && idx < 20; c++) begin
      bit acc;
      acc = (mq.size() != DEPTH);
      cycle(1, 32'(idx * 4), 32'h13 + 32'(idx), idx[0], 1'($urandom_range(0, 1)), 0);
      if (acc) idx++;
    end
    for (int c = 0; c < 64 && mq.size() != 0; c++)
      cycle(0, 0, 0, 0, 1, 0);
    check("stream_in", 64'(idx), 64'd20);
    check("stream_out", 64'(out_cnt), 64'd20);

    // flush beats a same-cycle enqueue and dequeue
    for (int i = 0; i < 5; i++)
      cycle(1, 32'h3000 + 32'(i * 4), 32'hC000 + 32'(i), 0, 0, 0);
    check("pre_flush_count", {60'd0, count}, 64'd5);
    cycle(1, 32'hBAD, 32'hBAD, 1, 1, 1);
    check("flush_count", {60'd0, count}, 64'd0);
    check("flush_deq_valid", {63'd0, deq_valid}, 64'd0);
    check("flush_enq_ready", {63'd0, enq_ready}, 64'd1);
    cycle(1, 32'h300, 32'h33, 0, 0, 0);
    check("post_flush_pc", {32'd0, deq_pc}, 64'h300);
    cycle(0, 0, 0, 0, 1, 0);

    // asynchronous reset mid-operation, between edges
    for (int i = 0; i < 3; i++)
      cycle(1, 32'h4000 + 32'(i * 4), 32'hD000 + 32'(i), 1, 0, 0);
    check("pre_rst_count", {60'd0, count}, 64'd3);
    #2 rst = 1'b0;
    #1;
    check("async_count", {60'd0, count}, 64'd0);
    check("async_deq_valid", {63'd0, deq_valid}, 64'd0);
    check("async_enq_ready", {63'd0, enq_ready}, 64'd1);
    check("async_almost_full", {63'd0, almost_full}, 64'd0);
    #1 rst = 1'b1;
    mq.delete();
    @(posedge clk);
    #1;
    cycle(1, 32'h200, 32'h22, 0, 0, 0);
    check("post_rst_pc", {32'd0, deq_pc}, 64'h200);
    check("post_rst_count", {60'd0, count}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
